// File: rtl/debug_port_pkg.sv
// Shared command codes, mode bit positions and transfer-direction encoding for the
// nibble debug port.
package debug_port_pkg;

  localparam logic [3:0] CMD_NOP        = 4'd0;
  localparam logic [3:0] CMD_READ       = 4'd1;
  localparam logic [3:0] CMD_WRITE      = 4'd2;
  localparam logic [3:0] CMD_SET_ADDR   = 4'd3;
  localparam logic [3:0] CMD_FORCE_MOVE = 4'd4;
  localparam logic [3:0] CMD_SET_MODE   = 4'd5;
  localparam logic [3:0] CMD_CLR_ADDR   = 4'd6;
  localparam logic [3:0] CMD_STATUS     = 4'd7;

  localparam int unsigned MODE_AUTO_INC_BIT = 0;
  localparam int unsigned MODE_SAT_BIT      = 1;

  typedef enum logic {
    XferRead  = 1'b0,
    XferWrite = 1'b1
  } xfer_dir_e;

endpackage

// File: rtl/debug_addr_gen.sv
// Cell address register for the debug port: nibble-wise address entry, clear, and
// post-transfer auto-increment with wrap or saturate, plus an in-range flag.
module debug_addr_gen #(
  parameter int unsigned NUM_CELLS = 16,
  parameter int unsigned ADDR_W    = $clog2(NUM_CELLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_addr,
  input  logic [3:0]        nibble,
  input  logic              clr_addr,
  input  logic              advance,
  input  logic              auto_inc,
  input  logic              sat,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  localparam int unsigned AddrW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_CELLS - 1);
  localparam logic [ADDR_W:0]   NumCells = AddrW1'(NUM_CELLS);

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W+3:0]   shifted;

  // MSB nibble is entered first, so older nibbles shift up and fall off the top.
  assign shifted = {addr_q, nibble};

  always_comb begin
    addr_d = addr_q;
    if (clr_addr) begin
      addr_d = '0;
    end else if (set_addr) begin
      addr_d = shifted[ADDR_W-1:0];
    end else if (advance && auto_inc) begin
      // Out-of-range addresses take the same wrap/saturate path as the last cell.
      if (addr_q >= LastAddr) begin
        addr_d = sat ? LastAddr : '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr     = addr_q;
  assign in_range = ({1'b0, addr_q} < NumCells);

endmodule

// File: rtl/debug_port_ctrl.sv
// Nibble-wide debug port bridging the uio pins to the game grid with multi-beat cell
// transfers. Define DEBUG_STATUS_EN to build the STATUS (command 7) read-back.
module debug_port_ctrl
  import debug_port_pkg::*;
#(
  parameter int unsigned CELL_W    = 4,
  parameter int unsigned NUM_CELLS = 16,
  parameter int unsigned ADDR_W    = $clog2(NUM_CELLS),
  parameter int unsigned BEATS     = (CELL_W + 3) / 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        debug_en,
  input  logic [7:0]                  uio_in,
  output logic [7:0]                  uio_out,
  output logic [7:0]                  uio_oe,
  input  logic [NUM_CELLS*CELL_W-1:0] grid_in,
  output logic                        grid_out_valid,
  output logic [ADDR_W-1:0]           grid_out_addr,
  output logic [CELL_W-1:0]           grid_out_data,
  output logic [3:0]                  force_move
);

  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ASM_W = BEATS * 4;
  localparam logic [BCW-1:0] LastBeat = BCW'(BEATS - 1);

  logic [3:0] cmd, din;
  assign cmd = uio_in[3:0];
  assign din = uio_in[7:4];

  logic [BCW-1:0]    beat_q, beat_d;
  xfer_dir_e         xfer_q, xfer_d;
  logic              auto_inc_q, auto_inc_d;
  logic              sat_q, sat_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [3:0]        rd_nib_q, rd_nib_d;
  logic              rd_oe_q, rd_oe_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CELL_W-1:0] wr_data_q, wr_data_d;
  logic [3:0]        force_q, force_d;

  logic              set_addr, clr_addr, advance;
  logic [ADDR_W-1:0] addr;
  logic              in_range;

  debug_addr_gen #(
    .NUM_CELLS (NUM_CELLS),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_addr (set_addr),
    .nibble   (din),
    .clr_addr (clr_addr),
    .advance  (advance),
    .auto_inc (auto_inc_q),
    .sat      (sat_q),
    .addr     (addr),
    .in_range (in_range)
  );

  // Selected cell, zero-padded to whole nibbles; out-of-range addresses read as 0.
  logic [ASM_W-1:0] cell_rd;
  always_comb begin
    cell_rd = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (addr == ADDR_W'(i)) begin
        cell_rd[CELL_W-1:0] = grid_in[i*CELL_W +: CELL_W];
      end
    end
  end

  // A READ/WRITE that reverses a partial sequence restarts at beat 0.
  xfer_dir_e        cmd_dir;
  logic [BCW-1:0]   eff_beat;
  logic             last_beat;
  logic [3:0]       rd_nib;
  logic [ASM_W-1:0] asm_wr;

  always_comb begin
    cmd_dir   = (cmd == CMD_WRITE) ? XferWrite : XferRead;
    eff_beat  = ((beat_q != '0) && (xfer_q != cmd_dir)) ? '0 : beat_q;
    last_beat = (eff_beat == LastBeat);
    rd_nib    = '0;
    asm_wr    = asm_q;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (eff_beat == BCW'(b)) begin
        rd_nib         = cell_rd[b*4 +: 4];
        asm_wr[b*4 +: 4] = din;
      end
    end
  end

  always_comb begin
    beat_d     = beat_q;
    xfer_d     = xfer_q;
    auto_inc_d = auto_inc_q;
    sat_d      = sat_q;
    asm_d      = asm_q;
    rd_nib_d   = '0;
    rd_oe_d    = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    force_d    = '0;
    set_addr   = 1'b0;
    clr_addr   = 1'b0;
    advance    = 1'b0;

    if (!debug_en) begin
      beat_d = '0;
    end else begin
      case (cmd)
        CMD_READ: begin
          xfer_d   = XferRead;
          rd_nib_d = rd_nib;
          rd_oe_d  = 1'b1;
          advance  = last_beat;
          beat_d   = last_beat ? '0 : eff_beat + BCW'(1);
        end
        CMD_WRITE: begin
          xfer_d  = XferWrite;
          asm_d   = asm_wr;
          advance = last_beat;
          beat_d  = last_beat ? '0 : eff_beat + BCW'(1);
          if (last_beat && in_range) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr;
            wr_data_d  = asm_wr[CELL_W-1:0];
          end
        end
        CMD_SET_ADDR: begin
          set_addr = 1'b1;
          beat_d   = '0;
        end
        CMD_FORCE_MOVE: force_d = din;
        CMD_SET_MODE: begin
          auto_inc_d = din[MODE_AUTO_INC_BIT];
          sat_d      = din[MODE_SAT_BIT];
        end
        CMD_CLR_ADDR: begin
          clr_addr = 1'b1;
          beat_d   = '0;
        end
`ifdef DEBUG_STATUS_EN
        CMD_STATUS: begin
          rd_nib_d = {xfer_q, sat_q, auto_inc_q, beat_q != '0};
          rd_oe_d  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      xfer_q     <= XferRead;
      auto_inc_q <= 1'b1;
      sat_q      <= 1'b0;
      asm_q      <= '0;
      rd_nib_q   <= '0;
      rd_oe_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      force_q    <= '0;
    end else begin
      beat_q     <= beat_d;
      xfer_q     <= xfer_d;
      auto_inc_q <= auto_inc_d;
      sat_q      <= sat_d;
      asm_q      <= asm_d;
      rd_nib_q   <= rd_nib_d;
      rd_oe_q    <= rd_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      force_q    <= force_d;
    end
  end

  assign uio_out        = {rd_nib_q, 4'b0000};
  assign uio_oe         = {{4{rd_oe_q}}, 4'b0000};
  assign grid_out_valid = wr_valid_q;
  assign grid_out_addr  = wr_addr_q;
  assign grid_out_data  = wr_data_q;
  assign force_move     = force_q;

endmodule

// File: tb/tb_debug_port_ctrl.sv
// Randomized and directed stimulus for debug_port_ctrl, checked every cycle against a
// cell-level behavioural model of the debug port.
module tb_debug_port_ctrl;

  localparam int CELL_W    = 6;
  localparam int NUM_CELLS = 12;
  localparam int ADDR_W    = $clog2(NUM_CELLS);
  localparam int BEATS     = (CELL_W + 3) / 4;
  localparam int GRID_W    = NUM_CELLS * CELL_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                debug_en = 1'b0;
  logic [7:0]          uio_in = '0;
  logic [7:0]          uio_out, uio_oe;
  logic [GRID_W-1:0]   grid = '0;
  logic                grid_out_valid;
  logic [ADDR_W-1:0]   grid_out_addr;
  logic [CELL_W-1:0]   grid_out_data;
  logic [3:0]          force_move;

  debug_port_ctrl #(
    .CELL_W    (CELL_W),
    .NUM_CELLS (NUM_CELLS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .debug_en       (debug_en),
    .uio_in         (uio_in),
    .uio_out        (uio_out),
    .uio_oe         (uio_oe),
    .grid_in        (grid),
    .grid_out_valid (grid_out_valid),
    .grid_out_addr  (grid_out_addr),
    .grid_out_data  (grid_out_data),
    .force_move     (force_move)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: address, position inside the current cell, direction of the
  // partial transfer, mode flags, and the nibbles written so far.
  int m_addr, m_beat, m_dir, m_auto, m_sat;
  int m_nib[BEATS];
  int e_rd, e_oe, e_valid, e_gaddr, e_gdata, e_fm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_addr = 0; m_beat = 0; m_dir = 0; m_auto = 1; m_sat = 0;
    foreach (m_nib[k]) m_nib[k] = 0;
    e_rd = 0; e_oe = 0; e_valid = 0; e_gaddr = 0; e_gdata = 0; e_fm = 0;
  endtask

  function automatic int cell_value(input int a);
    logic [GRID_W-1:0] sh;
    if (a >= NUM_CELLS) return 0;
    sh = grid >> (a * CELL_W);
    return int'(sh[CELL_W-1:0]);
  endfunction

  task automatic model_clock(input bit en, input int cmd, input int d);
    int dir, val;
    e_rd = 0; e_oe = 0; e_valid = 0; e_fm = 0;
    if (!en) begin
      m_beat = 0;
      return;
    end
    case (cmd)
      1, 2: begin
        dir = (cmd == 2) ? 1 : 0;
        if (m_beat != 0 && m_dir != dir) m_beat = 0;
        m_dir = dir;
        if (cmd == 1) begin
          e_rd = (cell_value(m_addr) >> (4 * m_beat)) & 15;
          e_oe = 1;
        end else begin
          if (m_beat == 0) foreach (m_nib[k]) m_nib[k] = 0;
          m_nib[m_beat] = d;
        end
        if (m_beat == BEATS - 1) begin
          if (cmd == 2 && m_addr < NUM_CELLS) begin
            val = 0;
            for (int k = 0; k < BEATS; k++) val = val | (m_nib[k] << (4 * k));
            e_valid = 1;
            e_gaddr = m_addr;
            e_gdata = val % (1 << CELL_W);
          end
          m_beat = 0;
          if (m_auto != 0) begin
            if (m_addr >= NUM_CELLS - 1) m_addr = (m_sat != 0) ? NUM_CELLS - 1 : 0;
            else m_addr = m_addr + 1;
          end
        end else begin
          m_beat = m_beat + 1;
        end
      end
      3: begin
        m_addr = (m_addr * 16 + d) % (1 << ADDR_W);
        m_beat = 0;
      end
      4: e_fm = d;
      5: begin
        m_auto = d % 2;
        m_sat  = (d / 2) % 2;
      end
      6: begin
        m_addr = 0;
        m_beat = 0;
      end
`ifdef DEBUG_STATUS_EN
      7: begin
        e_rd = m_dir * 8 + m_sat * 4 + m_auto * 2 + ((m_beat != 0) ? 1 : 0);
        e_oe = 1;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".uio_out"}, 32'(uio_out), 32'(e_rd << 4));
    check_eq({tag, ".uio_oe"}, 32'(uio_oe), (e_oe != 0) ? 32'hF0 : 32'h0);
    check_eq({tag, ".valid"}, 32'(grid_out_valid), 32'(e_valid));
    check_eq({tag, ".gaddr"}, 32'(grid_out_addr), 32'(e_gaddr));
    check_eq({tag, ".gdata"}, 32'(grid_out_data), 32'(e_gdata));
    check_eq({tag, ".force"}, 32'(force_move), 32'(e_fm));
  endtask

  // Called at a negedge: drive, clock, update model, then sample on the next negedge.
  task automatic step(input string tag, input bit en, input int cmd, input int d);
    logic [3:0] c4, d4;
    c4 = 4'(cmd);
    d4 = 4'(d);
    debug_en = en;
    uio_in   = {d4, c4};
    @(posedge clk);
    model_clock(en, cmd, d);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic set_cell(input int a, input int v);
    logic [CELL_W-1:0] v6;
    v6 = CELL_W'(v);
    grid[a*CELL_W +: CELL_W] = v6;
  endtask

  initial begin
    logic [95:0] rnd;
    int r, cmd, d;
    bit en;

    model_reset();
    rnd  = {$urandom, $urandom, $urandom};
    grid = rnd[GRID_W-1:0];
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Read of cell 5 across both beats, then auto-increment to cell 6.
    set_cell(5, 6'h2A);
    set_cell(6, 6'h17);
    step("sa5", 1, 3, 5);
    step("rd5b0", 1, 1, 0);
    step("rd5b1", 1, 1, 0);
    step("rd6b0", 1, 1, 0);
    step("nop", 1, 0, 0);

    // Two-beat write to cell 2, then the next write lands on cell 3.
    step("sa2", 1, 3, 2);
    step("wr2b0", 1, 2, 3);
    step("wr2b1", 1, 2, 2);
    step("wr3b0", 1, 2, 9);
    step("wr3b1", 1, 2, 1);

    // Wrap at the last cell, then saturate.
    step("sa11", 1, 3, 11);
    step("rd11b0", 1, 1, 0);
    step("rd11b1", 1, 1, 0);
    step("rd0b0", 1, 1, 0);
    step("mode3", 1, 5, 3);
    step("sa11s", 1, 3, 11);
    step("rd11s0", 1, 1, 0);
    step("rd11s1", 1, 1, 0);
    step("rd11s2", 1, 1, 0);

    // Out-of-range cell: reads zero, write completes silently.
    step("sa13", 1, 3, 13);
    step("rd13", 1, 1, 0);
    step("wr13b0", 1, 2, 5);
    step("wr13b1", 1, 2, 6);
    step("mode1", 1, 5, 1);

    // Partial write abandoned by a read.
    step("sa4", 1, 3, 4);
    step("wr4p", 1, 2, 1);
    step("rd4", 1, 1, 0);
    step("rd4b1", 1, 1, 0);

    // Force-move pulse only when enabled; two-nibble address entry.
    step("fm_en", 1, 4, 4);
    step("fm_gap", 1, 0, 0);
    step("fm_dis", 0, 4, 4);
    step("sa_hi", 1, 3, 1);
    step("sa_lo", 1, 3, 7);
    step("rd7", 1, 1, 0);

    // Reset in the middle of a two-beat write with a pulse still on the outputs.
    step("clr", 1, 6, 0);
    step("wrp", 1, 2, 7);
    step("fm_rst", 1, 4, 9);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("wr0b0", 1, 2, 4);
    step("wr0b1", 1, 2, 3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        rnd  = {$urandom, $urandom, $urandom};
        grid = rnd[GRID_W-1:0];
      end
      r   = $urandom_range(0, 9);
      cmd = (r < 3) ? 1 : (r < 6) ? 2 : (r == 6) ? 3 : $urandom_range(0, 15);
      d   = $urandom_range(0, 15);
      en  = ($urandom_range(0, 15) != 0);
      step("rand", en, cmd, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
